tmds_encoder: RTL and testbench

- Per-channel DVI/TMDS 8b/10b encoder.
- Sits between the vga timing/pixel stage and the 10:1 serializer in the HDMI output path, one instance per colour channel.
- Converts 8-bit pixel data, or 2 control bits during blanking, into DC-balanced 10-bit symbols per DVI 1.0 §3.2.
- Two-stage pipeline; tracks running disparity.

---
 rtl/tmds_encoder.sv | 129 ++++++++++++
 tb/tb_tmds_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// tmds_encoder: per-channel DVI/TMDS 8b/10b encoder, two-stage pipeline.
// Stage 1 transition-minimises the pixel byte into q_m[8:0]; stage 2 applies
// DC balancing against a signed running disparity and emits the 10-bit symbol.
// Optional feature macro: TMDS_ENCODER_DISPARITY_OUT_EN exposes the running
// disparity (value after the update for the symbol on tmds) as a port.
module tmds_encoder (
    input  logic              clk,
    input  logic              rst,
    input  logic              de,
    input  logic [7:0]        data,
    input  logic [1:0]        c,
`ifdef TMDS_ENCODER_DISPARITY_OUT_EN
    output logic [9:0]        tmds,
    output logic signed [4:0] disparity
`else
    output logic [9:0]        tmds
`endif
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Stage 1 registers
    logic       de_s1;
    logic [1:0] c_s1;
    logic [8:0] qm_s1;

    // Stage 2 state
    logic signed [4:0] cnt;

    // Stage 1 combinational signals
    logic [3:0] n1_data;
    logic       use_xnor;
    logic [8:0] qm_next;

    // Stage 2 combinational signals
    logic [3:0]        n1_qm;
    logic [3:0]        n0_qm;
    logic signed [4:0] diff;
    logic signed [4:0] two_qm8;
    logic signed [4:0] two_nqm8;
    logic [9:0]        tmds_next;
    logic signed [4:0] cnt_next;

    // Transition minimisation: choose XOR or XNOR chaining from the ones count
    always_comb begin
        n1_data  = ones8(data);
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
        qm_next  = '0;
        qm_next[0] = data[0];
        for (int i = 1; i < 8; i++) begin
            qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ data[i])
                                  :  (qm_next[i-1] ^ data[i]);
        end
        qm_next[8] = ~use_xnor;
    end

    // Stage 1 register: latch de, control bits and q_m
    always_ff @(posedge clk) begin
        if (rst) begin
            de_s1 <= 1'b0;
            c_s1  <= 2'b00;
            qm_s1 <= '0;
        end else begin
            de_s1 <= de;
            c_s1  <= c;
            qm_s1 <= qm_next;
        end
    end

    // DC balancing: pick symbol polarity and the new running disparity
    always_comb begin
        n1_qm    = ones8(qm_s1[7:0]);
        n0_qm    = 4'd8 - n1_qm;
        // N1-N0 lies in -8..8, so 5 signed bits hold it exactly
        diff     = $signed({1'b0, n1_qm}) - $signed({1'b0, n0_qm});
        two_qm8  = $signed({3'b000, qm_s1[8], 1'b0});
        two_nqm8 = $signed({3'b000, ~qm_s1[8], 1'b0});
        tmds_next = CTRL_00;
        cnt_next  = cnt;
        if (!de_s1) begin
            cnt_next = 5'sd0;
            case (c_s1)
                2'b00:   tmds_next = CTRL_00;
                2'b01:   tmds_next = CTRL_01;
                2'b10:   tmds_next = CTRL_10;
                default: tmds_next = CTRL_11;
            endcase
        end else if ((cnt == 5'sd0) || (n1_qm == n0_qm)) begin
            tmds_next = {~qm_s1[8], qm_s1[8],
                         qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
            cnt_next  = qm_s1[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1_qm > n0_qm)) ||
                     ((cnt < 5'sd0) && (n0_qm > n1_qm))) begin
            tmds_next = {1'b1, qm_s1[8], ~qm_s1[7:0]};
            cnt_next  = cnt + two_qm8 - diff;
        end else begin
            tmds_next = {1'b0, qm_s1[8], qm_s1[7:0]};
            cnt_next  = cnt + diff - two_nqm8;
        end
    end

    // Stage 2 register: output symbol and running disparity
    always_ff @(posedge clk) begin
        if (rst) begin
            tmds <= CTRL_00;
            cnt  <= 5'sd0;
        end else begin
            tmds <= tmds_next;
            cnt  <= cnt_next;
        end
    end

`ifdef TMDS_ENCODER_DISPARITY_OUT_EN
    assign disparity = cnt;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: scoreboard bench for tmds_encoder. The driver pushes the
// symbol expected on tmds after each clock edge; a negedge monitor pops and
// compares. Directed sections push hand-computed values, the soak pushes
// values from a behavioural reference model.
module tb_tmds_encoder;

    logic              clk;
    logic              rst;
    logic              de;
    logic [7:0]        data;
    logic [1:0]        c;
    logic [9:0]        tmds;
`ifdef TMDS_ENCODER_DISPARITY_OUT_EN
    logic signed [4:0] disparity;
`endif

    // entry: {is_data, data[7:0], cnt[4:0], tmds[9:0]}
    logic [23:0] exp_q[$];

    int total;
    int bad;
    logic finishing;
    logic mon_done;
    int   drain_wait;

    // model state: pending stage-1 contents and running disparity
    logic       p_de;
    logic [7:0] p_data;
    logic [1:0] p_c;
    int         m_cnt;

    tmds_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .de        (de),
        .data      (data),
        .c         (c),
`ifdef TMDS_ENCODER_DISPARITY_OUT_EN
        .disparity (disparity),
`endif
        .tmds      (tmds)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural reference encoder
    function automatic logic [9:0] ref_sym(input logic de_i, input logic [7:0] d,
                                           input logic [1:0] cc, input int cnt_in,
                                           output int cnt_out);
        int n1d, n1, n0;
        logic xn;
        logic [8:0] q;
        logic [9:0] s;
        if (!de_i) begin
            cnt_out = 0;
            case (cc)
                2'b00:   s = 10'h354;
                2'b01:   s = 10'h0AB;
                2'b10:   s = 10'h154;
                default: s = 10'h2AB;
            endcase
            return s;
        end
        n1d = 0;
        for (int i = 0; i < 8; i++) n1d += int'(d[i]);
        xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(q[i]);
        n0 = 8 - n1;
        if (cnt_in == 0 || n1 == n0) begin
            s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cnt_out = q[8] ? cnt_in + n1 - n0 : cnt_in + n0 - n1;
        end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
            s = {1'b1, q[8], ~q[7:0]};
            cnt_out = cnt_in + 2 * int'(q[8]) + n0 - n1;
        end else begin
            s = {1'b0, q[8], q[7:0]};
            cnt_out = cnt_in + n1 - n0 - 2 * int'(!q[8]);
        end
        return s;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    // driver: apply one cycle of inputs and push what tmds must show after the edge
    task automatic drive(input logic r, input logic d_e, input logic [7:0] d,
                         input logic [1:0] cc, input logic hand,
                         input logic [9:0] h_tmds, input int h_cnt);
        logic [9:0] sym;
        int         nc;
        logic       isdat;
        logic [7:0] dd;
        rst  = r;
        de   = d_e;
        data = d;
        c    = cc;
        if (r) begin
            sym = 10'h354; nc = 0; isdat = 1'b0; dd = 8'h00;
            p_de = 1'b0; p_data = 8'h00; p_c = 2'b00;
        end else begin
            sym = ref_sym(p_de, p_data, p_c, m_cnt, nc);
            isdat = p_de; dd = p_data;
            p_de = d_e; p_data = d; p_c = cc;
        end
        m_cnt = nc;
        if (hand) exp_q.push_back({isdat, dd, 5'(h_cnt), h_tmds});
        else      exp_q.push_back({isdat, dd, 5'(nc), sym});
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [23:0] e;
        logic [7:0]  dec;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (tmds !== e[9:0]) begin
                bad++;
                $display("FAIL tmds t=%0t got=%h want=%h", $time, tmds, e[9:0]);
            end
            if (e[23]) begin
                dec = decode(tmds);
                total++;
                if (dec !== e[22:15]) begin
                    bad++;
                    $display("FAIL decode t=%0t got=%h want=%h", $time, dec, e[22:15]);
                end
            end
`ifdef TMDS_ENCODER_DISPARITY_OUT_EN
            total++;
            if (disparity !== $signed(e[14:10])) begin
                bad++;
                $display("FAIL disparity t=%0t got=%0d want=%0d", $time, disparity,
                         $signed(e[14:10]));
            end
            total++;
            if (disparity > 5'sd10 || disparity < -5'sd10) begin
                bad++;
                $display("FAIL disp_range t=%0t got=%0d want=|x|<=10", $time, disparity);
            end
`endif
        end else if (finishing) begin
            mon_done <= 1'b1;
        end
        if (finishing && exp_q.size() > 0) begin
            drain_wait++;
            if (drain_wait > 10) begin
                bad++;
                $display("FAIL drain got=%0d left want=0", exp_q.size());
                exp_q.delete();
            end
        end
    end

    // stimulus and final report
    initial begin
        logic       r_de;
        logic       r_rst;
        total = 0; bad = 0; finishing = 1'b0; mon_done = 1'b0; drain_wait = 0;
        p_de = 1'b0; p_data = 8'h00; p_c = 2'b00; m_cnt = 0;
        rst = 1'b1; de = 1'b0; data = 8'h00; c = 2'b00;

        // reset held 3 cycles, then 2 idle cycles
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);

        // control codes 00,01,10,11 with two-cycle latency
        drive(1'b0, 1'b0, 8'hA5, 2'b01, 1'b1, 10'h354, 0);
        drive(1'b0, 1'b0, 8'h5A, 2'b10, 1'b1, 10'h0AB, 0);
        drive(1'b0, 1'b0, 8'hFF, 2'b11, 1'b1, 10'h154, 0);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h2AB, 0);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);

        // disparity sequence: two 0x00 pixels from cnt=0
        drive(1'b0, 1'b1, 8'h00, 2'b11, 1'b1, 10'h354, 0);
        drive(1'b0, 1'b1, 8'h00, 2'b11, 1'b1, 10'h100, -8);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h3FF, 2);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);

        // XNOR path: 0xFF from cnt=0
        drive(1'b0, 1'b1, 8'hFF, 2'b00, 1'b1, 10'h354, 0);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h200, -8);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);

        // blanking resets disparity between two 0x00 pixels
        drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h354, 0);
        drive(1'b0, 1'b0, 8'hFF, 2'b00, 1'b1, 10'h100, -8);
        drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h354, 0);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h100, -8);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);

        // mid-line reset flushes both stages
        drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h354, 0);
        drive(1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8);
        drive(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h354, 0);
        drive(1'b0, 1'b1, 8'hFF, 2'b00, 1'b1, 10'h354, 0);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h200, -8);
        drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);

        // soak against the reference model, with runs of de and rare resets
        r_de = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) r_de = ~r_de;
            r_rst = ($urandom_range(0, 299) == 0);
            drive(r_rst, r_de, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                  1'b0, 10'h000, 0);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 10'h000, 0);

        finishing = 1'b1;
        for (int i = 0; i < 30 && !mon_done; i++) @(posedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_done got=0 want=1");
            $fatal(1, "monitor did not finish");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
